// File: rtl/ctrl_pkg.sv
// Shared definitions for the RAM-driver address generator and the header table.
// Holds the controller FSM state encoding and the default width constants.
package ctrl_pkg;

    localparam int unsigned DefDataOffsetWidth  = 10;
    localparam int unsigned DefVectorIndexWidth = 4;
    localparam int unsigned DefAddrWidth        = 12;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWrite,
        StRead,
        StInc,
        StDone
    } ctrl_state_e;

endpackage

// File: rtl/ctrl_ramdrv_addrgen_if.sv
// Bus between the address generator and its environment (sequencer, header table, MAC).
//   master: start/index/base/length requests, head_offset from the header table,
//           addr_ready from the MAC; observes strobes, RAM address and status.
//   slave : the address generator.
interface ctrl_ramdrv_addrgen_if #(
    parameter int unsigned DATA_OFFSET_WIDTH  = ctrl_pkg::DefDataOffsetWidth,
    parameter int unsigned VECTOR_INDEX_WIDTH = ctrl_pkg::DefVectorIndexWidth,
    parameter int unsigned ADDR_WIDTH         = ctrl_pkg::DefAddrWidth
);
    logic                          start;
    logic [VECTOR_INDEX_WIDTH-1:0] index;
    logic [ADDR_WIDTH-1:0]         base;
    logic [DATA_OFFSET_WIDTH-1:0]  length;
    logic [DATA_OFFSET_WIDTH-1:0]  head_offset;
    logic                          addr_ready;
    logic                          hdr_read;
    logic                          hdr_inc;
    logic [VECTOR_INDEX_WIDTH-1:0] hdr_index;
    logic [ADDR_WIDTH-1:0]         ram_addr;
    logic                          ram_we;
    logic                          ram_re;
    logic                          tap_last;
    logic                          busy;
    logic                          done;

    modport master (
        output start, index, base, length, head_offset, addr_ready,
        input  hdr_read, hdr_inc, hdr_index, ram_addr, ram_we, ram_re, tap_last, busy, done
    );

    modport slave (
        input  start, index, base, length, head_offset, addr_ready,
        output hdr_read, hdr_inc, hdr_index, ram_addr, ram_we, ram_re, tap_last, busy, done
    );
endinterface

// File: rtl/ctrl_ring_ptr.sv
// Ring read pointer: loadable down-counter that wraps from zero to length.
//   clk, rst    : clock, synchronous active-high reset (clears pointer)
//   load_i      : load load_val_i (takes priority over en_i)
//   load_val_i  : value to load
//   en_i        : step the pointer one position backwards
//   length_i    : wrap target after zero (last valid ring offset)
//   ptr_o       : current pointer
module ctrl_ring_ptr #(
    parameter int unsigned WIDTH = ctrl_pkg::DefDataOffsetWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] length_i,
    output logic [WIDTH-1:0] ptr_o
);
    logic [WIDTH-1:0] ptr_q, ptr_d;

    // Wrap only on exactly zero, so a loaded value above length still walks down and
    // wraps normally instead of locking up.
    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = load_val_i;
        end else if (en_i) begin
            ptr_d = (ptr_q == '0) ? length_i : ptr_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;
endmodule

// File: rtl/ctrl_ramdrv_addrgen.sv
// Delay-line address generator: for one delay line, fetches the head pointer, writes the
// new sample at base+head, then walks length+1 read addresses backwards around the ring
// (valid/ready towards the MAC), bumps the header head pointer and pulses done.
//   clk, rst : clock, synchronous active-high reset
//   bus_io   : slave side of ctrl_ramdrv_addrgen_if (requests in, strobes/addresses out)
module ctrl_ramdrv_addrgen
    import ctrl_pkg::*;
#(
    parameter int unsigned DATA_OFFSET_WIDTH  = DefDataOffsetWidth,
    parameter int unsigned VECTOR_INDEX_WIDTH = DefVectorIndexWidth,
    parameter int unsigned ADDR_WIDTH         = DefAddrWidth
) (
    input  logic                  clk,
    input  logic                  rst,
    ctrl_ramdrv_addrgen_if.slave  bus_io
);
    ctrl_state_e state_q, state_d;

    logic [VECTOR_INDEX_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]         base_q, base_d;
    logic [DATA_OFFSET_WIDTH-1:0]  len_q, len_d;
    logic [DATA_OFFSET_WIDTH-1:0]  k_q, k_d;
    logic [DATA_OFFSET_WIDTH-1:0]  ptr;
    logic [ADDR_WIDTH-1:0]         addr_sum;
    logic                          read_accept;
    logic                          last_tap;

    assign read_accept = (state_q == StRead) && bus_io.addr_ready;
    assign last_tap    = (k_q == len_q);

    // The pointer holds the captured head through WRITE, so one adder serves both the
    // write and the reads; it depends on registers only, never on addr_ready.
    assign addr_sum = base_q + ADDR_WIDTH'(ptr);

    ctrl_ring_ptr #(
        .WIDTH (DATA_OFFSET_WIDTH)
    ) u_ring_ptr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == StFetch),
        .load_val_i (bus_io.head_offset),
        .en_i       (read_accept),
        .length_i   (len_q),
        .ptr_o      (ptr)
    );

    // State register and request latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            len_q   <= len_d;
            k_q     <= k_d;
        end
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus_io.start) state_d = StFetch;
            StFetch: state_d = StWrite;
            StWrite: state_d = StRead;
            StRead:  if (read_accept && last_tap) state_d = StInc;
            StInc:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request latches and tap counter.
    always_comb begin
        idx_d  = idx_q;
        base_d = base_q;
        len_d  = len_q;
        k_d    = k_q;
        if (state_q == StIdle && bus_io.start) begin
            idx_d  = bus_io.index;
            base_d = bus_io.base;
            len_d  = bus_io.length;
        end
        if (state_q == StFetch) begin
            k_d = '0;
        end else if (read_accept) begin
            k_d = k_q + DATA_OFFSET_WIDTH'(1);
        end
    end

    // Outputs decoded from state only.
    always_comb begin
        bus_io.hdr_read  = 1'b0;
        bus_io.hdr_inc   = 1'b0;
        bus_io.hdr_index = '0;
        bus_io.ram_addr  = '0;
        bus_io.ram_we    = 1'b0;
        bus_io.ram_re    = 1'b0;
        bus_io.tap_last  = 1'b0;
        bus_io.busy      = 1'b0;
        bus_io.done      = 1'b0;
        unique case (state_q)
            StFetch: begin
                bus_io.hdr_read  = 1'b1;
                bus_io.hdr_index = idx_q;
                bus_io.busy      = 1'b1;
            end
            StWrite: begin
                bus_io.ram_we   = 1'b1;
                bus_io.ram_addr = addr_sum;
                bus_io.busy     = 1'b1;
            end
            StRead: begin
                bus_io.ram_re   = 1'b1;
                bus_io.ram_addr = addr_sum;
                bus_io.tap_last = last_tap;
                bus_io.busy     = 1'b1;
            end
            StInc: begin
                bus_io.hdr_inc   = 1'b1;
                bus_io.hdr_index = idx_q;
                bus_io.busy      = 1'b1;
            end
            StDone: begin
                bus_io.done = 1'b1;
            end
            default: begin
            end
        endcase
    end
endmodule
